pzbcm_stream_mux: RTL and testbench

PZBCM_STREAM_MUX -- requirements
Module: pzbcm_stream_mux

---
 rtl/pzbcm_stream_mux_pkg.sv | 42 ++++
 rtl/pzbcm_selector.sv | 24 ++
 rtl/pzbcm_stream_mux_slice.sv | 73 +++++++
 rtl/pzbcm_stream_mux.sv | 127 ++++++++++++
 tb/tb_pzbcm_stream_mux.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pzbcm_stream_mux_pkg.sv
// Shared types and helpers for the stream multiplexer.
//   state_e       : packet-lock state (IDLE, LOCKED)
//   select_t      : decoded select {hit, index}
//   decode_select : turns a raw select word into an input index
package pzbcm_stream_mux_pkg;

  localparam int MAX_ENTRIES = 32;
  localparam int MAX_INDEX_WIDTH = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  typedef struct packed {
    logic                       hit;
    logic [MAX_INDEX_WIDTH-1:0] index;
  } select_t;

  // One-hot: lowest set bit wins. Binary: out-of-range index selects nothing.
  function automatic select_t decode_select(
    input logic [MAX_ENTRIES-1:0] select,
    input int                     entries,
    input bit                     one_hot
  );
    select_t result;
    result = '0;
    if (one_hot) begin
      for (int i = MAX_ENTRIES - 1; i >= 0; i--) begin
        if ((i < entries) && select[i]) begin
          result.hit   = 1'b1;
          result.index = MAX_INDEX_WIDTH'(i);
        end
      end
    end else if (select < MAX_ENTRIES'(entries)) begin
      result.hit   = 1'b1;
      result.index = select[MAX_INDEX_WIDTH-1:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/pzbcm_selector.sv
// Binary-indexed payload multiplexer.
//   i_index : binary index of the entry to forward
//   i_data  : unpacked array of ENTRIES payloads
//   o_data  : selected payload, '0 when the index is out of range
module pzbcm_selector #(
  parameter type TYPE        = logic [7:0],
  parameter int  ENTRIES     = 2,
  localparam int INDEX_WIDTH = $clog2(ENTRIES)
) (
  input  logic [INDEX_WIDTH-1:0] i_index,
  input  TYPE                    i_data [ENTRIES],
  output TYPE                    o_data
);

  always_comb begin
    o_data = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (i_index == INDEX_WIDTH'(i)) begin
        o_data = i_data[i];
      end
    end
  end

endmodule

// File: rtl/pzbcm_stream_mux_slice.sv
// Output register slice for the stream multiplexer, carrying {data, last}.
//   i_clk, i_rst_n     : clock, synchronous active-low reset
//   i_valid/o_ready/i_data : upstream side (i_valid must already be qualified by o_ready)
//   o_valid/i_ready/o_data : downstream side
// Build option PZBCM_STREAM_MUX_SKID_EN: 2-entry skid buffer with a registered o_ready.
// Default build: single register whose o_ready follows i_ready combinationally.
module pzbcm_stream_mux_slice #(
  parameter int WIDTH = 9
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  assign o_valid = valid_q;
  assign o_data  = data_q;

`ifdef PZBCM_STREAM_MUX_SKID_EN
  logic             skid_valid_q;
  logic [WIDTH-1:0] skid_data_q;

  // Ready comes straight from a flop, so i_ready never reaches upstream.
  assign o_ready = !skid_valid_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q      <= 1'b0;
      data_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else if (!valid_q || i_ready) begin
      // Main stage free this cycle: drain the skid entry first to keep order.
      if (skid_valid_q) begin
        valid_q      <= 1'b1;
        data_q       <= skid_data_q;
        skid_valid_q <= 1'b0;
      end else begin
        valid_q <= i_valid && o_ready;
        if (i_valid && o_ready) begin
          data_q <= i_data;
        end
      end
    end else if (i_valid && o_ready) begin
      // Main stage stalled: park the beat accepted under the old ready.
      skid_valid_q <= 1'b1;
      skid_data_q  <= i_data;
    end
  end
`else
  assign o_ready = !valid_q || i_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (i_valid && o_ready) begin
      valid_q <= 1'b1;
      data_q  <= i_data;
    end else if (i_ready) begin
      valid_q <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/pzbcm_stream_mux.sv
// Packet-aware N:1 stream multiplexer. The select is sampled only between packets;
// once a non-final beat is accepted the chosen input stays locked until its last beat.
//   i_clk, i_rst_n  : clock, synchronous active-low reset
//   i_select        : one-hot (ONE_HOT=1) or binary (ONE_HOT=0) input select
//   i_valid/o_ready/i_data/i_last : per-input stream ports
//   o_valid/i_ready/o_data/o_last : merged output stream
//   o_locked        : high while a packet is in progress
// Build option PZBCM_STREAM_MUX_SKID_EN selects the skid-buffer output slice.
module pzbcm_stream_mux
  import pzbcm_stream_mux_pkg::*;
#(
  parameter int  WIDTH        = 8,
  parameter type TYPE         = logic [WIDTH-1:0],
  parameter int  ENTRIES      = 2,
  parameter int  ONE_HOT      = 1,
  localparam int INDEX_WIDTH  = $clog2(ENTRIES),
  localparam int SELECT_WIDTH = (ONE_HOT != 0) ? ENTRIES : INDEX_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [SELECT_WIDTH-1:0] i_select,
  input  logic [ENTRIES-1:0]      i_valid,
  output logic [ENTRIES-1:0]      o_ready,
  input  TYPE                     i_data [ENTRIES],
  input  logic [ENTRIES-1:0]      i_last,
  output logic                    o_valid,
  input  logic                    i_ready,
  output TYPE                     o_data,
  output logic                    o_last,
  output logic                    o_locked
);

  localparam int DATA_WIDTH = $bits(TYPE);

  state_e                  state_q, state_d;
  logic [INDEX_WIDTH-1:0]  index_q, index_d;
  logic [MAX_ENTRIES-1:0]  select_ext;
  select_t                 select_dec;
  logic                    eff_hit;
  logic [INDEX_WIDTH-1:0]  eff_index;
  logic                    slice_ready;
  logic                    in_valid;
  logic                    in_last;
  TYPE                     mux_data;
  logic [DATA_WIDTH:0]     slice_in;
  logic [DATA_WIDTH:0]     slice_out;

  always_comb begin
    select_ext                 = '0;
    select_ext[SELECT_WIDTH-1:0] = i_select;
    select_dec                 = decode_select(select_ext, ENTRIES, ONE_HOT != 0);
  end

  always_comb begin
    if (state_q == LOCKED) begin
      eff_hit   = 1'b1;
      eff_index = index_q;
    end else begin
      eff_hit   = select_dec.hit;
      eff_index = select_dec.index[INDEX_WIDTH-1:0];
    end
  end

  // Gating with i_rst_n keeps every ready low while reset is asserted.
  always_comb begin
    o_ready = '0;
    if (i_rst_n && eff_hit && slice_ready) begin
      o_ready[eff_index] = 1'b1;
    end
  end

  // At most one ready bit is set, so reductions pick the selected input's flags.
  assign in_valid = |(i_valid & o_ready);
  assign in_last  = |(i_last & o_ready);

  pzbcm_selector #(
    .TYPE    (TYPE),
    .ENTRIES (ENTRIES)
  ) u_binary_mux (
    .i_index (eff_index),
    .i_data  (i_data),
    .o_data  (mux_data)
  );

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    if (in_valid) begin
      if (in_last) begin
        state_d = IDLE;
      end else if (state_q == IDLE) begin
        state_d = LOCKED;
        index_d = eff_index;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  assign o_locked = (state_q == LOCKED);
  assign slice_in = {mux_data, in_last};

  pzbcm_stream_mux_slice #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_slice (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (in_valid),
    .o_ready (slice_ready),
    .i_data  (slice_in),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (slice_out)
  );

  assign o_data = slice_out[DATA_WIDTH:1];
  assign o_last = slice_out[0];

endmodule

// File: tb/tb_pzbcm_stream_mux.sv
// Bench for pzbcm_stream_mux: three configurations (4-input binary, 4-input one-hot,
// 3-input binary). The 4-input binary instance is tracked cycle by cycle against a
// queue model of beats in flight.
module tb_pzbcm_stream_mux;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance 0: ENTRIES=4, binary select
  logic [1:0] sel0;
  logic [3:0] valid0, ready0, last0;
  logic [7:0] data0 [4];
  logic       ovalid0, iready0, olast0, olocked0;
  logic [7:0] odata0;

  // Instance 1: ENTRIES=4, one-hot select
  logic [3:0] sel1, valid1, ready1, last1;
  logic [7:0] data1 [4];
  logic       ovalid1, iready1, olast1, olocked1;
  logic [7:0] odata1;

  // Instance 2: ENTRIES=3, binary select
  logic [1:0] sel2;
  logic [2:0] valid2, ready2, last2;
  logic [7:0] data2 [3];
  logic       ovalid2, iready2, olast2, olocked2;
  logic [7:0] odata2;

  pzbcm_stream_mux #(.WIDTH(8), .ENTRIES(4), .ONE_HOT(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_select(sel0), .i_valid(valid0), .o_ready(ready0),
    .i_data(data0), .i_last(last0), .o_valid(ovalid0), .i_ready(iready0), .o_data(odata0),
    .o_last(olast0), .o_locked(olocked0)
  );

  pzbcm_stream_mux #(.WIDTH(8), .ENTRIES(4), .ONE_HOT(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_select(sel1), .i_valid(valid1), .o_ready(ready1),
    .i_data(data1), .i_last(last1), .o_valid(ovalid1), .i_ready(iready1), .o_data(odata1),
    .o_last(olast1), .o_locked(olocked1)
  );

  pzbcm_stream_mux #(.WIDTH(8), .ENTRIES(3), .ONE_HOT(0)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_select(sel2), .i_valid(valid2), .o_ready(ready2),
    .i_data(data2), .i_last(last2), .o_valid(ovalid2), .i_ready(iready2), .o_data(odata2),
    .o_last(olast2), .o_locked(olocked2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model for instance 0: beats accepted but not yet delivered, in order.
  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t      m_q[$];
  bit         m_locked = 1'b0;
  int         m_index  = 0;
  int         m_idx;
  bit         m_hit;
  bit         m_accept;
  logic [3:0] m_ready;
  beat_t      m_beat;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("ready_in_reset", 32'(ready0), 32'd0);
      m_q.delete();
      m_locked = 1'b0;
      m_index  = 0;
    end else begin
      if (m_locked) begin
        m_hit = 1'b1;
        m_idx = m_index;
      end else begin
        m_idx = int'(sel0);
        m_hit = (m_idx < 4);
      end
`ifdef PZBCM_STREAM_MUX_SKID_EN
      m_accept = (m_q.size() < 2);
`else
      m_accept = (m_q.size() == 0) || iready0;
`endif
      m_ready = (m_hit && m_accept) ? 4'(1 << m_idx) : 4'd0;
      chk("model_ready", 32'(ready0), 32'(m_ready));
      chk("model_valid", 32'(ovalid0), 32'(m_q.size() != 0));
      chk("model_locked", 32'(olocked0), 32'(m_locked));
      if (m_q.size() != 0) begin
        chk("model_data", 32'(odata0), 32'(m_q[0].data));
        chk("model_last", 32'(olast0), 32'(m_q[0].last));
        if (iready0) void'(m_q.pop_front());
      end
      if (m_ready[m_idx] && valid0[m_idx]) begin
        m_beat.data = data0[m_idx];
        m_beat.last = last0[m_idx];
        m_q.push_back(m_beat);
        if (last0[m_idx]) begin
          m_locked = 1'b0;
        end else if (!m_locked) begin
          m_locked = 1'b1;
          m_index  = m_idx;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pos;
    rst_n = 1'b0;
    sel0 = '0; valid0 = '0; last0 = '0; iready0 = 1'b1;
    sel1 = '0; valid1 = '0; last1 = '0; iready1 = 1'b1;
    sel2 = '0; valid2 = '0; last2 = '0; iready2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data0[i] = '0;
      data1[i] = '0;
    end
    for (int i = 0; i < 3; i++) data2[i] = '0;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    chk("rst_valid0", 32'(ovalid0), 32'd0);
    chk("rst_locked0", 32'(olocked0), 32'd0);
    chk("rst_data0", 32'(odata0), 32'd0);
    chk("rst_last0", 32'(olast0), 32'd0);
    chk("rst_valid1", 32'(ovalid1), 32'd0);
    chk("rst_valid2", 32'(ovalid2), 32'd0);
    tick();
    rst_n = 1'b1;

    // 3-beat packet on input 2, select moved to 1 mid-packet
    tick();
    sel0 = 2'd2; valid0 = 4'b0100; data0[2] = 8'hA1; last0 = 4'b0000;
    @(negedge clk);
    chk("pkt_ready_b1", 32'(ready0), 32'h4);
    tick();
    sel0 = 2'd1; valid0 = 4'b0110; data0[1] = 8'h55; data0[2] = 8'hA2;
    @(negedge clk);
    chk("pkt_data_b1", 32'(odata0), 32'hA1);
    chk("pkt_locked_b1", 32'(olocked0), 32'd1);
    chk("pkt_ready_b2", 32'(ready0), 32'h4);
    tick();
    data0[2] = 8'hA3; last0 = 4'b0100;
    @(negedge clk);
    chk("pkt_data_b2", 32'(odata0), 32'hA2);
    chk("pkt_locked_b2", 32'(olocked0), 32'd1);
    chk("pkt_ready_b3", 32'(ready0), 32'h4);
    tick();
    valid0 = 4'b0000; last0 = 4'b0000;
    @(negedge clk);
    chk("pkt_data_b3", 32'(odata0), 32'hA3);
    chk("pkt_last_b3", 32'(olast0), 32'd1);
    chk("pkt_unlocked", 32'(olocked0), 32'd0);
    chk("pkt_new_select", 32'(ready0), 32'h2);
    tick();
    @(negedge clk);
    chk("pkt_drained", 32'(ovalid0), 32'd0);

    // Continuous stream on input 0: one beat per cycle
    tick();
    sel0 = 2'd0; valid0 = 4'b0001; data0[0] = 8'h10; last0 = 4'b0000;
    @(negedge clk);
    chk("cont_ready", 32'(ready0), 32'h1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      data0[0] = 8'(8'h10 + i);
      last0 = (i == 5) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      chk("cont_data", 32'(odata0), 32'(8'h10 + i - 1));
      chk("cont_valid", 32'(ovalid0), 32'd1);
    end
    tick();
    valid0 = 4'b0000; last0 = 4'b0000;
    @(negedge clk);
    chk("cont_data_end", 32'(odata0), 32'h15);
    chk("cont_last_end", 32'(olast0), 32'd1);

    // Downstream stall of 5 cycles mid-stream on input 3
    pos = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      sel0    = (c == 0) ? 2'd3 : 2'(c);
      iready0 = !(c >= 1 && c <= 5);
      valid0  = (pos < 6) ? 4'b1000 : 4'b0000;
      data0[3] = 8'(8'h30 + pos);
      last0   = (pos == 5) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      if (c >= 1 && c <= 5) begin
        chk("stall_data", 32'(odata0), 32'h30);
        chk("stall_valid", 32'(ovalid0), 32'd1);
      end
      if (valid0[3] && ready0[3]) pos++;
    end
    chk("stall_all_sent", 32'(pos), 32'd6);
    tick();
    valid0 = '0; last0 = '0; iready0 = 1'b1; sel0 = 2'd0;
    tick();
    @(negedge clk);
    chk("stall_drained", 32'(ovalid0), 32'd0);

    // Reset while locked with a beat held
    tick();
    sel0 = 2'd0; valid0 = 4'b0001; data0[0] = 8'h77; last0 = 4'b0000; iready0 = 1'b0;
    @(negedge clk);
    chk("rstmid_ready", 32'(ready0), 32'h1);
    tick();
    rst_n = 1'b0; valid0 = 4'b0000;
    @(negedge clk);
    chk("rstmid_pre_valid", 32'(ovalid0), 32'd1);
    chk("rstmid_pre_locked", 32'(olocked0), 32'd1);
    tick();
    rst_n = 1'b1; sel0 = 2'd2; valid0 = 4'b0100; data0[2] = 8'h88; last0 = 4'b0100;
    iready0 = 1'b1;
    @(negedge clk);
    chk("rstmid_valid", 32'(ovalid0), 32'd0);
    chk("rstmid_locked", 32'(olocked0), 32'd0);
    chk("rstmid_data", 32'(odata0), 32'd0);
    chk("rstmid_ready_new", 32'(ready0), 32'h4);
    tick();
    valid0 = 4'b0000; last0 = 4'b0000;
    @(negedge clk);
    chk("rstmid_new_data", 32'(odata0), 32'h88);
    chk("rstmid_new_last", 32'(olast0), 32'd1);

    // One-hot select: lowest set bit wins
    tick();
    sel1 = 4'b0110; valid1 = 4'b0110; data1[1] = 8'hB1; data1[2] = 8'hB2;
    last1 = 4'b0110;
    @(negedge clk);
    chk("oh_ready", 32'(ready1), 32'h2);
    tick();
    valid1 = 4'b0000; sel1 = 4'b0000;
    @(negedge clk);
    chk("oh_valid", 32'(ovalid1), 32'd1);
    chk("oh_data", 32'(odata1), 32'hB1);
    chk("oh_locked", 32'(olocked1), 32'd0);
    tick();
    valid1 = 4'b1111;
    @(negedge clk);
    chk("oh_zero_ready", 32'(ready1), 32'd0);
    tick();
    sel1 = 4'b1000;
    @(negedge clk);
    chk("oh_top_ready", 32'(ready1), 32'h8);
    tick();
    valid1 = 4'b0000;

    // Out-of-range binary index selects nothing
    sel2 = 2'd3; valid2 = 3'b111; data2[0] = 8'hC0; data2[1] = 8'hC1; data2[2] = 8'hC2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("oor_ready", 32'(ready2), 32'd0);
      chk("oor_valid", 32'(ovalid2), 32'd0);
      tick();
    end
    valid2 = 3'b000;

    // Randomized traffic on instance 0 against the queue model
    for (int c = 0; c < 400; c++) begin
      tick();
      rst_n   = ($urandom_range(0, 59) != 0);
      sel0    = 2'($urandom);
      valid0  = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        data0[i]  = 8'($urandom);
        last0[i]  = ($urandom_range(0, 2) == 0);
      end
      iready0 = ($urandom_range(0, 3) != 0);
    end
    tick();
    rst_n = 1'b1; valid0 = '0; last0 = '0; iready0 = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("rand_drained", 32'(ovalid0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
